fib_store_checker: RTL

// - Synthesisable, self-checking result monitor for the superscalar MIPS core. It replaces time-based end-of-run dumps of data memory.
// - Snoops up to LANES data-memory store ports per cycle and regenerates the expected Fibonacci terms internally.
// - Checks that each store into the result window carries the next term, in address order.
// - Reports pass, fail or timeout with a sticky status. Sits beside dmem; the bench or an FPGA LED/UART reads the status.

---
 rtl/fib_store_checker_pkg.sv | 29 ++
 rtl/fib_store_checker_term_gen.sv | 54 +++++
 rtl/fib_store_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fib_store_checker_pkg.sv
// Shared encodings and helpers for the Fibonacci store checker.
// Pure definitions: no logic, no latency.
package fib_chk_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_PASS = 3'd2;
  localparam logic [2:0] ST_FAIL = 3'd3;
  localparam logic [2:0] ST_TMO  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    PASS = ST_PASS,
    FAIL = ST_FAIL,
    TMO  = ST_TMO
  } state_t;

  localparam logic [1:0] FAIL_NONE  = 2'd0;
  localparam logic [1:0] FAIL_DATA  = 2'd1;
  localparam logic [1:0] FAIL_ORDER = 2'd2;
  localparam logic [1:0] FAIL_TMO   = 2'd3;

  // Byte address to word index; callers zero-extend narrower addresses.
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/fib_store_checker_term_gen.sv
// Holds the pair (F(n),F(n+1)) and produces LANES lookahead terms F(n+2).. via an add chain.
// Pair update is registered; terms are combinational. No backpressure.
module fib_term_gen #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  localparam int AW    = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       seed0,
  input  logic [DATA_W-1:0]       seed1,
  input  logic [AW-1:0]           adv,
  output logic [LANES*DATA_W-1:0] terms
);

  logic [DATA_W-1:0] a, b;
  logic [DATA_W-1:0] nxt_a, nxt_b;

  always_comb begin
    logic [DATA_W-1:0] x, y, z;
    x     = a;
    y     = b;
    z     = '0;
    nxt_a = a;
    nxt_b = b;
    terms = '0;
    for (int k = 0; k < LANES; k++) begin
      z = x + y;
      terms[k*DATA_W +: DATA_W] = z;
      // Advancing by k+1 terms leaves the pair sitting on (y, z).
      if (adv == AW'(k + 1)) begin
        nxt_a = y;
        nxt_b = z;
      end
      x = y;
      y = z;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= seed0;
      b <= seed1;
    end else if (load) begin
      a <= seed0;
      b <= seed1;
    end else begin
      a <= nxt_a;
      b <= nxt_b;
    end
  end

endmodule

// File: rtl/fib_store_checker.sv
// Snoops dmem store lanes and checks the Fibonacci result window; FIB_CHK_ERRCAP_EN adds error capture.
// Outputs registered, valid the edge after the deciding cycle; passive snoop, never backpressures.
module fib_store_checker
  import fib_chk_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                LANES     = 2,
  parameter int                BASE_WORD = 2,
  parameter int                NUM_TERMS = 10,
  parameter logic [DATA_W-1:0] SEED0     = '0,
  parameter logic [DATA_W-1:0] SEED1     = DATA_W'(1),
  parameter int                TIMEOUT   = 300,
  localparam int               TW        = $clog2(NUM_TERMS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LANES-1:0]         st_valid,
  input  logic [LANES*ADDR_W-1:0]  st_addr,
  input  logic [LANES*DATA_W-1:0]  st_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [TW-1:0]            terms_seen,
  output logic [ADDR_W-1:0]        err_addr,
  output logic [DATA_W-1:0]        err_data,
  output logic [DATA_W-1:0]        err_expect
);

`ifdef FIB_CHK_ERRCAP_EN
  // One extra lookahead term gives the next expected value after a full-width match on a timeout cycle.
  localparam int GEN_N = LANES + 1;
`else
  localparam int GEN_N = LANES;
`endif
  localparam int          AW       = $clog2(GEN_N + 1);
  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [63:0] WIN_LO   = 64'(BASE_WORD);
  localparam logic [63:0] WIN_HI   = 64'(BASE_WORD + NUM_TERMS);

  state_t                   state, state_n;
  logic [CW-1:0]            cyc;
  logic [GEN_N*DATA_W-1:0]  terms;
  logic [AW-1:0]            nmatch;
  logic                     run, hit_err, hit_done, to_tmo, tmo_hit;
  logic [1:0]               code_n;
`ifdef FIB_CHK_ERRCAP_EN
  logic [ADDR_W-1:0]        e_addr;
  logic [DATA_W-1:0]        e_data, e_exp;
`endif

  assign run     = (state == RUN) && !start;
  assign tmo_hit = (TIMEOUT != 0) && (32'(cyc) == 32'(TMO_LAST));

  fib_term_gen #(.DATA_W(DATA_W), .LANES(GEN_N)) u_gen (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .seed0 (SEED0),
    .seed1 (SEED1),
    .adv   (run ? nmatch : '0),
    .terms (terms)
  );

  always_comb begin
    logic              stop;
    logic [63:0]       widx, want;
    logic [DATA_W-1:0] want_dat;
    stop     = 1'b0;
    widx     = '0;
    want     = '0;
    want_dat = '0;
    nmatch   = '0;
    hit_err  = 1'b0;
    hit_done = 1'b0;
    to_tmo   = 1'b0;
    code_n   = fail_code;
`ifdef FIB_CHK_ERRCAP_EN
    e_addr   = '0;
    e_data   = '0;
    e_exp    = '0;
`endif
    if (run) begin
      for (int k = 0; k < LANES; k++) begin
        widx     = word_idx(64'(st_addr[k*ADDR_W +: ADDR_W]));
        want     = WIN_LO + 64'(terms_seen) + 64'(nmatch);
        want_dat = '0;
        for (int j = 0; j < LANES; j++)
          if (32'(nmatch) == 32'(j)) want_dat = terms[j*DATA_W +: DATA_W];
        if (!stop && st_valid[k] && widx >= WIN_LO && widx < WIN_HI) begin
          if (widx != want || st_data[k*DATA_W +: DATA_W] != want_dat) begin
            stop    = 1'b1;
            hit_err = 1'b1;
            code_n  = (widx != want) ? FAIL_ORDER : FAIL_DATA;
`ifdef FIB_CHK_ERRCAP_EN
            e_addr  = st_addr[k*ADDR_W +: ADDR_W];
            e_data  = st_data[k*DATA_W +: DATA_W];
            e_exp   = want_dat;
`endif
          end else begin
            nmatch = nmatch + AW'(1);
            if (32'(terms_seen) + 32'(nmatch) == 32'(NUM_TERMS)) begin
              stop     = 1'b1;
              hit_done = 1'b1;
            end
          end
        end
      end
    end

    state_n = state;
    if (start) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (hit_err)       state_n = FAIL;
      else if (hit_done) state_n = PASS;
      else if (tmo_hit) begin
        state_n = TMO;
        code_n  = FAIL_TMO;
        to_tmo  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      terms_seen <= '0;
      fail_code  <= FAIL_NONE;
      cyc        <= '0;
    end else if (start) begin
      terms_seen <= '0;
      fail_code  <= FAIL_NONE;
      cyc        <= '0;
    end else if (run) begin
      terms_seen <= terms_seen + TW'(nmatch);
      fail_code  <= code_n;
      cyc        <= cyc + CW'(1);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL) || (state == TMO);
  assign pass = (state == PASS);

`ifdef FIB_CHK_ERRCAP_EN
  logic [DATA_W-1:0] tmo_exp;
  logic [63:0]       tmo_word;

  always_comb begin
    tmo_exp  = '0;
    tmo_word = WIN_LO + 64'(terms_seen) + 64'(nmatch);
    for (int j = 0; j < GEN_N; j++)
      if (32'(nmatch) == 32'(j)) tmo_exp = terms[j*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || start) begin
      err_addr   <= '0;
      err_data   <= '0;
      err_expect <= '0;
    end else if (hit_err) begin
      err_addr   <= e_addr;
      err_data   <= e_data;
      err_expect <= e_exp;
    end else if (to_tmo) begin
      err_addr   <= ADDR_W'(tmo_word << 2);
      err_data   <= '0;
      err_expect <= tmo_exp;
    end
  end
`else
  assign err_addr   = '0;
  assign err_data   = '0;
  assign err_expect = '0;
`endif

endmodule
